// File: rtl/fns_weight_scanner.sv
// Fibonacci-number-system weight scanner: walks a TSV group one line per step,
// assigns weights 1,2,3,5,8,... to the first N_DATA healthy TSVs and streams them out.
module fns_weight_scanner #(
  parameter int N_DATA  = 5,
  parameter int N_SPARE = 2,
  parameter int W       = 8,
  localparam int N      = N_DATA + N_SPARE,
  localparam int IW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [N-1:0]  f_flag,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic [N-1:0]  en_flag,
  output logic          w_valid,
  input  logic          w_ready,
  output logic [W-1:0]  w_data,
  output logic [IW-1:0] w_idx
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [IW:0] NDATA_C = (IW+1)'(N_DATA);
  localparam logic [IW:0] LAST_C  = (IW+1)'(N - 1);
  localparam logic [IW:0] ONE_C   = (IW+1)'(1);

  state_t         state_r;
  logic [N-1:0]   flags_r;
  logic [W-1:0]   b_r;
  logic [W-1:0]   f_r;
  logic [IW:0]    idx_r;
  logic [IW:0]    cnt_r;

  logic [IW-1:0]  pos_s;
  logic           last_s;
  logic [W-1:0]   sum_s;
  logic [IW:0]    cnt_inc_s;

  // idx and cnt are one bit wider than a TSV position, so they never wrap
  assign pos_s     = idx_r[IW-1:0];
  assign last_s    = (idx_r == LAST_C);
  assign sum_s     = b_r + f_r;
  assign cnt_inc_s = cnt_r + ONE_C;

  // Scan FSM with all outputs registered; done is a one-cycle pulse on entry to DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      flags_r <= '0;
      b_r     <= '0;
      f_r     <= W'(1);
      idx_r   <= '0;
      cnt_r   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      fail    <= 1'b0;
      en_flag <= '0;
      w_valid <= 1'b0;
      w_data  <= '0;
      w_idx   <= '0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            flags_r <= f_flag;
            b_r     <= '0;
            f_r     <= W'(1);
            idx_r   <= '0;
            cnt_r   <= '0;
            en_flag <= '0;
            fail    <= 1'b0;
            busy    <= 1'b1;
            state_r <= SCAN;
          end
        end
        SCAN: begin
          // faulty lines and surplus healthy spares are parked in one step
          if (flags_r[pos_s] || (cnt_r == NDATA_C)) begin
            en_flag[pos_s] <= 1'b0;
            idx_r          <= idx_r + ONE_C;
            if (last_s) begin
              state_r <= DONE;
              done    <= 1'b1;
              fail    <= (cnt_r < NDATA_C);
            end
          end else begin
            en_flag[pos_s] <= 1'b1;
            w_valid        <= 1'b1;
            w_data         <= sum_s;
            w_idx          <= pos_s;
            state_r        <= WAIT;
          end
        end
        WAIT: begin
          if (w_ready) begin
            w_valid <= 1'b0;
            b_r     <= f_r;
            f_r     <= sum_s;
            cnt_r   <= cnt_inc_s;
            idx_r   <= idx_r + ONE_C;
            if (last_s) begin
              state_r <= DONE;
              done    <= 1'b1;
              fail    <= (cnt_inc_s < NDATA_C);
            end else begin
              state_r <= SCAN;
            end
          end
        end
        DONE: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          w_valid <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fns_weight_scanner.sv
// Self-checking bench for fns_weight_scanner: directed and random scans checked
// against a reference that derives weights, enables and timing from the flag vector.
module tb_fns_weight_scanner;

  localparam int N_DATA  = 5;
  localparam int N_SPARE = 2;
  localparam int W       = 8;
  localparam int N       = N_DATA + N_SPARE;
  localparam int IW      = (N > 1) ? $clog2(N) : 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [N-1:0]  f_flag = '0;
  logic          w_ready = 1'b1;
  logic          busy;
  logic          done;
  logic          fail;
  logic [N-1:0]  en_flag;
  logic          w_valid;
  logic [W-1:0]  w_data;
  logic [IW-1:0] w_idx;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fns_weight_scanner #(.N_DATA(N_DATA), .N_SPARE(N_SPARE), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .f_flag(f_flag),
    .busy(busy), .done(done), .fail(fail), .en_flag(en_flag),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_idx(w_idx)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete scan: the reference walks the flags, hands out Fib(k+2) to the
  // first N_DATA healthy lines, and expects done N + D + stall cycles after start.
  task automatic test_scan(input string name, input logic [N-1:0] flags,
                           input int stall_k, input int stall_len, input bit poke);
    int exp_idx[$];
    int exp_w[$];
    int fib[0:N+2];
    logic [N-1:0] exp_en;
    logic exp_fail;
    logic [W-1:0] e_w;
    logic [IW-1:0] e_idx;
    int d, k, stalled, c, exp_done;
    bit seen_done;

    fib[0] = 0;
    fib[1] = 1;
    for (int i = 2; i <= N + 2; i++) fib[i] = fib[i-1] + fib[i-2];
    exp_en = '0;
    d = 0;
    for (int i = 0; i < N; i++) begin
      if (!flags[i] && d < N_DATA) begin
        exp_idx.push_back(i);
        exp_w.push_back(fib[d+2] % (1 << W));
        exp_en[i] = 1'b1;
        d++;
      end
    end
    exp_fail = (d < N_DATA);
    exp_done = N + d + ((stall_k < d) ? stall_len : 0);

    f_flag = flags;
    start = 1'b1;
    w_ready = 1'b1;
    step();
    start = 1'b0;
    f_flag = N'($urandom);
    k = 0;
    stalled = 0;
    c = 0;
    seen_done = 1'b0;
    while (!seen_done && c < 200) begin
      start = 1'b0;
      if (w_valid) begin
        if (k >= exp_w.size()) begin
          checks++;
          failures++;
          $display("FAIL %s extra_weight: got idx=%0d data=%0d, required no more weights", name, w_idx, w_data);
          w_ready = 1'b1;
        end else begin
          e_w = W'(exp_w[k]);
          e_idx = IW'(exp_idx[k]);
          checks++;
          if (w_data !== e_w || w_idx !== e_idx) begin
            failures++;
            $display("FAIL %s weight%0d: got idx=%0d data=%0d, required idx=%0d data=%0d",
                     name, k, w_idx, w_data, e_idx, e_w);
          end
          if (k == stall_k && stalled < stall_len) begin
            w_ready = 1'b0;
            stalled++;
          end else begin
            w_ready = 1'b1;
            k++;
          end
        end
      end else begin
        w_ready = 1'b1;
      end
      if (done) begin
        seen_done = 1'b1;
        checks++;
        if (c !== exp_done) begin
          failures++;
          $display("FAIL %s done_cycle: got %0d, required %0d", name, c, exp_done);
        end
        checks++;
        if (en_flag !== exp_en || fail !== exp_fail || busy !== 1'b1) begin
          failures++;
          $display("FAIL %s done_state: got en=%b fail=%b busy=%b, required en=%b fail=%b busy=1",
                   name, en_flag, fail, busy, exp_en, exp_fail);
        end
        checks++;
        if (k !== d) begin
          failures++;
          $display("FAIL %s weight_count: got %0d, required %0d", name, k, d);
        end
      end else if (poke && busy && $urandom_range(0, 2) == 0) begin
        start = 1'b1;
        f_flag = N'($urandom);
      end
      if (!seen_done) begin
        step();
        c++;
      end
    end
    if (!seen_done) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: got no done after %0d cycles, required done at %0d", name, c, exp_done);
    end
    start = 1'b0;
    w_ready = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || en_flag !== exp_en || fail !== exp_fail) begin
      failures++;
      $display("FAIL %s after_done: got busy=%b done=%b en=%b fail=%b, required 0 0 %b %b",
               name, busy, done, en_flag, fail, exp_en, exp_fail);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    f_flag = '0;
    step();
    step();
    checks++;
    if ({busy, done, fail, w_valid} !== 4'b0000 || en_flag !== '0 || w_data !== '0 || w_idx !== '0) begin
      failures++;
      $display("FAIL reset_values: got busy=%b done=%b fail=%b valid=%b en=%b data=%0d idx=%0d, required all 0",
               busy, done, fail, w_valid, en_flag, w_data, w_idx);
    end
    rst_n = 1'b1;
    start = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_beats_start: got busy=%b, required 0", busy);
    end
  endtask

  task automatic test_no_fault();      test_scan("no_fault", 7'b0000000, 99, 0, 1'b0); endtask
  task automatic test_single_fault();  test_scan("single_fault", 7'b0000100, 99, 0, 1'b0); endtask
  task automatic test_two_faults();    test_scan("two_faults", 7'b0001010, 99, 0, 1'b0); endtask
  task automatic test_short_group();   test_scan("short_group", 7'b0010011, 99, 0, 1'b0); endtask
  task automatic test_all_faulty();    test_scan("all_faulty", 7'b1111111, 99, 0, 1'b0); endtask
  task automatic test_backpressure();  test_scan("backpressure", 7'b0000000, 1, 3, 1'b1); endtask

  task automatic test_reset_mid_wait();
    int bad;
    f_flag = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    w_ready = 1'b0;
    for (int i = 0; i < 10 && !w_valid; i++) step();
    checks++;
    if (w_valid !== 1'b1) begin
      failures++;
      $display("FAIL midwait_reach: got w_valid=%b, required 1", w_valid);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if ({busy, done, fail, w_valid} !== 4'b0000 || en_flag !== '0 || w_data !== '0 || w_idx !== '0) begin
      failures++;
      $display("FAIL midwait_reset: got busy=%b done=%b fail=%b valid=%b en=%b data=%0d idx=%0d, required all 0",
               busy, done, fail, w_valid, en_flag, w_data, w_idx);
    end
    rst_n = 1'b1;
    w_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0 || w_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL midwait_quiet: got %0d cycles with activity, required 0", bad);
    end
    test_scan("after_reset", 7'b0000000, 99, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      test_scan("random", N'($urandom), $urandom_range(0, 5), $urandom_range(0, 3),
                1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_no_fault();
    test_single_fault();
    test_two_faults();
    test_short_group();
    test_all_faulty();
    test_backpressure();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
